// File: rtl/ysyx_23060332_dmem_resp_if.sv
// Request/response channel between the LSU path (master) and the data-memory responder (slave).
interface ysyx_23060332_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic        req_ren;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_ren, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_ren, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_23060332_dmem_resp.sv
// Data-memory responder: one request at a time, byte-masked stores, read snapshot at accept,
// fixed-latency response on a valid/ready channel.
module ysyx_23060332_dmem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_23060332_dmem_resp_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     mem [DEPTH];

  logic            ready_q, valid_q, err_q, hold_err;
  logic [31:0]     rdata_q, hold_rdata;
  logic            ready_n, valid_n, err_n;
  logic [31:0]     rdata_n;

  logic [31:0]     offset;
  logic            in_range, accept, wr_en;
  logic [AW-1:0]   idx;
  logic [31:0]     snap_rdata;
  logic            snap_err;
  logic            unused;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Modular subtraction makes addresses below the base land far above SPAN, so one compare suffices.
  assign offset   = bus.req_addr - ADDR_BASE;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];
  assign accept   = bus.req_valid & ready_q;
  assign wr_en    = accept & bus.req_wen & in_range;
  assign unused   = ^bus.req_wmask[7:4];

  // Response payload as it would be captured at the accept edge.
  always_comb begin
    snap_rdata = 32'd0;
    snap_err   = 1'b0;
    if (!in_range) begin
      snap_err = 1'b1;
    end else if (bus.req_ren && !bus.req_wen) begin
      snap_rdata = mem[idx];
    end
  end

  // RAM is deliberately left out of reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_wmask[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // State, counter, payload hold and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_rdata <= 32'd0;
      hold_err   <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= ready_n;
      valid_q <= valid_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      if (accept) begin
        hold_rdata <= snap_rdata;
        hold_err   <= snap_err;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = BUSY;
            cnt_n   = CW'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_n = RESP;
        else           cnt_n   = cnt - CW'(1);
      end
      RESP: begin
        if (bus.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; payload is zero unless a response is presented.
  always_comb begin
    ready_n = (state_n == IDLE);
    valid_n = (state_n == RESP);
    rdata_n = 32'd0;
    err_n   = 1'b0;
    if (valid_n) begin
      rdata_n = accept ? snap_rdata : hold_rdata;
      err_n   = accept ? snap_err   : hold_err;
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=1 responder, scoreboarded against a word model.
module tb_ysyx_23060332_dmem_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060332_dmem_resp_if b2();
  ysyx_23060332_dmem_resp_if b1();

  ysyx_23060332_dmem_resp #(.DEPTH(1024), .ADDR_BASE(32'h8000_0000), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  ysyx_23060332_dmem_resp #(.DEPTH(1024), .ADDR_BASE(32'h8000_0000), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, wen = 1'b0, ren = 1'b0, resp_ready = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [7:0]  wmask = 8'd0;

  assign b2.req_valid  = req_valid & ~sel;
  assign b1.req_valid  = req_valid & sel;
  assign b2.resp_ready = resp_ready & ~sel;
  assign b1.resp_ready = resp_ready & sel;
  assign b2.req_wen = wen;   assign b1.req_wen = wen;
  assign b2.req_ren = ren;   assign b1.req_ren = ren;
  assign b2.req_addr = addr; assign b1.req_addr = addr;
  assign b2.req_wdata = wdata; assign b1.req_wdata = wdata;
  assign b2.req_wmask = wmask; assign b1.req_wmask = wmask;

  wire        obs_ready = sel ? b1.req_ready  : b2.req_ready;
  wire        obs_valid = sel ? b1.resp_valid : b2.resp_valid;
  wire [31:0] obs_rdata = sel ? b1.resp_rdata : b2.resp_rdata;
  wire        obs_err   = sel ? b1.resp_err   : b2.resp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][1024];
  int          errors = 0;
  int          checks = 0;

  // One full transaction: expectation from the model, drive, measure latency, hold, handshake.
  task automatic xact(input bit s, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input logic [7:0] m, input int hold);
    exp_t e;
    int   k;
    int   lat;
    int   wi;
    lat = s ? 1 : 2;
    e   = '0;
    if (a >= 32'h8000_0000 && a < 32'h8000_1000) begin
      wi = int'((a - 32'h8000_0000) >> 2);
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) model[s][wi][8*i +: 8] = d[8*i +: 8];
        end
      end else if (r) begin
        e.rdata = model[s][wi];
      end
    end else begin
      e.err = 1'b1;
    end
    sb.push_back(e);

    @(negedge clk);
    sel = s; req_valid = 1'b1; wen = w; ren = r; addr = a; wdata = d; wmask = m;
    #1;
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle addr=%h: got %b want 1", a, obs_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (obs_valid === 1'b1) break;
    end
    checks++;
    if (k !== lat) begin
      errors++; $display("FAIL latency addr=%h: got %0d cycles want %0d", a, k, lat);
    end

    e = sb.pop_front();
    checks++;
    if (obs_rdata !== e.rdata) begin
      errors++; $display("FAIL rdata addr=%h: got %h want %h", a, obs_rdata, e.rdata);
    end
    checks++;
    if (obs_err !== e.err) begin
      errors++; $display("FAIL err addr=%h: got %b want %b", a, obs_err, e.err);
    end
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++; $display("FAIL req_ready_resp addr=%h: got %b want 0", a, obs_ready);
    end

    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (obs_valid !== 1'b1 || obs_rdata !== e.rdata || obs_err !== e.err || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc=%0d: got v=%b d=%h e=%b r=%b want v=1 d=%h e=%b r=0",
                 c, obs_valid, obs_rdata, obs_err, obs_ready, e.rdata, e.err);
      end
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_valid !== 1'b0 || obs_rdata !== 32'd0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL resp_clear addr=%h: got v=%b d=%h e=%b want 0/0/0", a, obs_valid, obs_rdata, obs_err);
    end
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after addr=%h: got %b want 1", a, obs_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (b2.req_ready !== 1'b1 || b2.resp_valid !== 1'b0 || b2.resp_rdata !== 32'd0 || b2.resp_err !== 1'b0 ||
        b1.req_ready !== 1'b1 || b1.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got r=%b v=%b d=%h e=%b want r=1 v=0 d=0 e=0",
               b2.req_ready, b2.resp_valid, b2.resp_rdata, b2.resp_err);
    end
    rst = 1'b0;

    // Accept a load, then reset while it is in BUSY.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; wen = 1'b0; ren = 1'b1; addr = 32'h8000_0000; wmask = 8'h00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++;
    if (b2.req_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready: got %b want 0", b2.req_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b2.resp_valid !== 1'b0 || b2.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_async: got v=%b r=%b want v=0 r=1", b2.resp_valid, b2.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (b2.resp_valid !== 1'b0 || b2.req_ready !== 1'b1) begin
        errors++; $display("FAIL reset_no_resp cyc=%0d: got v=%b r=%b want v=0 r=1", c, b2.resp_valid, b2.req_ready);
      end
    end
  endtask

  task automatic test_store_load();
    xact(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0,         8'h00, 0);
  endtask

  task automatic test_byte_mask();
    xact(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h1122_3344, 8'h05, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0012, 32'h0,         8'h00, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0,         8'h00, 0);
  endtask

  task automatic test_backpressure();
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0, 8'h00, 5);
  endtask

  task automatic test_range();
    xact(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 8'h0F, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h8000_0FFC, 32'h5A5A_5A5A, 8'h0F, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFC, 32'h0,         8'h00, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_1000, 32'h0,         8'h00, 2);
    xact(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0,         8'h00, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0FFC, 32'h0,         8'h00, 0);
  endtask

  task automatic test_latency1();
    xact(1'b1, 1'b1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 8'h0F, 0);
    xact(1'b1, 1'b0, 1'b1, 32'h8000_0020, 32'h0,         8'h00, 1);
    xact(1'b1, 1'b0, 1'b0, 32'h8000_0020, 32'h1234_5678, 8'h0F, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int n = 0; n < 8; n++) begin
      a = 32'h8000_0100 + 32'($urandom_range(0, 7) * 4);
      xact(1'b0, 1'b1, 1'b0, a, $urandom, 8'($urandom_range(0, 15)), 0);
      xact(1'b0, 1'b0, 1'b1, a, 32'h0, 8'h00, 0);
    end
    // Zero-mask store must leave the word alone.
    xact(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0BAD_0BAD, 8'h00, 0);
    xact(1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0,         8'h00, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      model[0][i] = 32'hx;
      model[1][i] = 32'hx;
    end
    test_reset();
    test_store_load();
    test_byte_mask();
    test_backpressure();
    test_range();
    test_latency1();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
